// File: rtl/piezo_sfx_arbiter.sv
// Four-way fixed-priority sound-effect arbiter driving one piezo with square-wave tones.
// Optional PIEZO_MUTE_EN adds a mute input that silences piezo_out without disturbing timing.
module piezo_sfx_arbiter #(
    parameter int unsigned HALF_P0 = 4,
    parameter int unsigned HALF_P1 = 3,
    parameter int unsigned HALF_P2 = 2,
    parameter int unsigned HALF_P3 = 1,
    parameter int unsigned DUR_MS  = 200,
    parameter int unsigned GAP_MS  = 20
) (
    input  logic       clk_1khz,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef PIEZO_MUTE_EN
    input  logic       mute,
`endif
    output logic       piezo_out,
    output logic       busy,
    output logic [1:0] active_id,
    output logic [3:0] grant,
    output logic       done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [9:0] DUR_LAST = 10'(DUR_MS - 1);
    localparam logic [9:0] GAP_LAST = 10'(GAP_MS - 1);
    localparam logic [2:0] H0_LAST  = 3'(HALF_P0 - 1);
    localparam logic [2:0] H1_LAST  = 3'(HALF_P1 - 1);
    localparam logic [2:0] H2_LAST  = 3'(HALF_P2 - 1);
    localparam logic [2:0] H3_LAST  = 3'(HALF_P3 - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic       piezo_q, piezo_d;
    logic [1:0] active_id_q, active_id_d;
    logic [3:0] grant_q, grant_d;
    logic       done_q, done_d;
    logic [2:0] tone_q, tone_d;
    logic [9:0] dur_q, dur_d;
    logic [9:0] gap_q, gap_d;

    logic [3:0] cand;
    logic [1:0] sel;
    logic [3:0] sel_onehot;
    logic [3:0] higher_mask;
    logic [2:0] half_last;
    logic       preempt;
    logic       start;

    always_comb begin
        cand = pending_q | req;
        if (cand[3])      sel = 2'd3;
        else if (cand[2]) sel = 2'd2;
        else if (cand[1]) sel = 2'd1;
        else              sel = 2'd0;
        sel_onehot = 4'b0001 << sel;

        case (active_id_q)
            2'd0:    begin higher_mask = 4'b1110; half_last = H0_LAST; end
            2'd1:    begin higher_mask = 4'b1100; half_last = H1_LAST; end
            2'd2:    begin higher_mask = 4'b1000; half_last = H2_LAST; end
            default: begin higher_mask = 4'b0000; half_last = H3_LAST; end
        endcase
        // Only live requests preempt; pending bits above active_id cannot exist during PLAY.
        preempt = (state_q == ST_PLAY) && |(req & higher_mask);
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | req;
        piezo_d     = piezo_q;
        active_id_d = active_id_q;
        grant_d     = '0;
        done_d      = 1'b0;
        tone_d      = tone_q;
        dur_d       = dur_q;
        gap_d       = gap_q;
        start       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start = |cand;
            end
            ST_PLAY: begin
                if (preempt) begin
                    start = 1'b1;
                end else if (dur_q == DUR_LAST) begin
                    piezo_d = 1'b0;
                    done_d  = 1'b1;
                    tone_d  = '0;
                    dur_d   = '0;
                    gap_d   = '0;
                    state_d = (GAP_MS == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    dur_d = dur_q + 10'd1;
                    if (tone_q == half_last) begin
                        tone_d  = '0;
                        piezo_d = ~piezo_q;
                    end else begin
                        tone_d = tone_q + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 10'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            state_d     = ST_PLAY;
            active_id_d = sel;
            grant_d     = sel_onehot;
            piezo_d     = 1'b1;
            tone_d      = '0;
            dur_d       = '0;
            pending_d   = cand & ~sel_onehot;
        end
    end

    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            piezo_q     <= 1'b0;
            active_id_q <= '0;
            grant_q     <= '0;
            done_q      <= 1'b0;
            tone_q      <= '0;
            dur_q       <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            piezo_q     <= piezo_d;
            active_id_q <= active_id_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            tone_q      <= tone_d;
            dur_q       <= dur_d;
            gap_q       <= gap_d;
        end
    end

`ifdef PIEZO_MUTE_EN
    assign piezo_out = piezo_q & ~mute;
`else
    assign piezo_out = piezo_q;
`endif
    assign busy      = (state_q != ST_IDLE);
    assign active_id = active_id_q;
    assign grant     = grant_q;
    assign done      = done_q;

endmodule

// File: tb/tb_piezo_sfx_arbiter.sv
// Directed self-checking bench for piezo_sfx_arbiter (mute scenario built only with PIEZO_MUTE_EN).
module tb_piezo_sfx_arbiter;

    logic       clk_1khz = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       piezo_out;
    logic       busy;
    logic [1:0] active_id;
    logic [3:0] grant;
    logic       done;
`ifdef PIEZO_MUTE_EN
    logic       mute;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_1khz = ~clk_1khz;

    piezo_sfx_arbiter #(
        .HALF_P0(4), .HALF_P1(3), .HALF_P2(2), .HALF_P3(1),
        .DUR_MS(200), .GAP_MS(20)
    ) dut (
        .clk_1khz (clk_1khz),
        .rst      (rst),
        .req      (req),
`ifdef PIEZO_MUTE_EN
        .mute     (mute),
`endif
        .piezo_out(piezo_out),
        .busy     (busy),
        .active_id(active_id),
        .grant    (grant),
        .done     (done)
    );

    task automatic tick;
        @(posedge clk_1khz);
        #1;
    endtask

    // Expected tone level c cycles into a tone with half-period h.
    function automatic logic exp_tone(input int h, input int c);
        return ((c / h) % 2) == 0;
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic [9:0] got;
        rst = 1'b0;
        req = 4'b0000;
`ifdef PIEZO_MUTE_EN
        mute = 1'b0;
`endif
        #1 rst = 1'b1;
        #2;
        got = {grant, piezo_out, busy, done, active_id};
        checks++;
        if (got !== 10'b0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", got, 10'b0);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        got = {grant, piezo_out, busy, done, active_id};
        checks++;
        if (got !== 10'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", got, 10'b0);
        end
    endtask

    task automatic test_single_tone;
        logic [9:0] got, exp;
        int dones;
        do_reset();
        dones = 0;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        for (int c = 0; c < 220; c++) begin
            exp = {(c == 0) ? 4'b0100 : 4'b0000, (c < 200) ? exp_tone(2, c) : 1'b0,
                   1'b1, (c == 200), 2'd2};
            got = {grant, piezo_out, busy, done, active_id};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL single_tone c=%0d got=%b exp=%b", c, got, exp);
            end
            if (done) dones++;
            tick();
        end
        checks++;
        if ({busy, grant, piezo_out} !== 6'b0) begin
            failures++;
            $display("FAIL single_tone_end busy=%b grant=%b piezo=%b exp all 0", busy, grant, piezo_out);
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL single_tone_dones got=%0d exp=1", dones);
        end
    endtask

    task automatic test_simultaneous;
        logic [9:0] got, exp;
        int dones;
        do_reset();
        dones = 0;
        req = 4'b0011;
        tick();
        req = 4'b0000;
        for (int c = 0; c < 220; c++) begin
            exp = {(c == 0) ? 4'b0010 : 4'b0000, (c < 200) ? exp_tone(3, c) : 1'b0,
                   1'b1, (c == 200), 2'd1};
            got = {grant, piezo_out, busy, done, active_id};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL simul_id1 c=%0d got=%b exp=%b", c, got, exp);
            end
            if (done) dones++;
            tick();
        end
        checks++;
        if ({busy, grant} !== 5'b0) begin
            failures++;
            $display("FAIL simul_idle busy=%b grant=%b exp 0", busy, grant);
        end
        tick();
        for (int c = 0; c < 220; c++) begin
            exp = {(c == 0) ? 4'b0001 : 4'b0000, (c < 200) ? exp_tone(4, c) : 1'b0,
                   1'b1, (c == 200), 2'd0};
            got = {grant, piezo_out, busy, done, active_id};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL simul_id0 c=%0d got=%b exp=%b", c, got, exp);
            end
            if (done) dones++;
            tick();
        end
        checks++;
        if (busy !== 1'b0 || dones !== 2) begin
            failures++;
            $display("FAIL simul_end busy=%b dones=%0d exp busy=0 dones=2", busy, dones);
        end
    endtask

    task automatic test_preempt;
        logic [9:0] got, exp;
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        for (int c = 0; c < 50; c++) begin
            exp = {(c == 0) ? 4'b0001 : 4'b0000, exp_tone(4, c), 1'b1, 1'b0, 2'd0};
            got = {grant, piezo_out, busy, done, active_id};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL preempt_id0 c=%0d got=%b exp=%b", c, got, exp);
            end
            tick();
        end
        req = 4'b1000;
        tick();
        req = 4'b0000;
        for (int c = 0; c < 220; c++) begin
            exp = {(c == 0) ? 4'b1000 : 4'b0000, (c < 200) ? exp_tone(1, c) : 1'b0,
                   1'b1, (c == 200), 2'd3};
            got = {grant, piezo_out, busy, done, active_id};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL preempt_id3 c=%0d got=%b exp=%b", c, got, exp);
            end
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({busy, grant} !== 5'b0) begin
                failures++;
                $display("FAIL preempt_no_replay c=%0d busy=%b grant=%b exp 0", c, busy, grant);
            end
            tick();
        end
    endtask

    task automatic test_low_during_play;
        logic [9:0] got, exp;
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        for (int c = 0; c < 220; c++) begin
            exp = {(c == 0) ? 4'b0100 : 4'b0000, (c < 200) ? exp_tone(2, c) : 1'b0,
                   1'b1, (c == 200), 2'd2};
            got = {grant, piezo_out, busy, done, active_id};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL low_id2 c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 10 || c == 30 || c == 60) req = 4'b0010;
            tick();
            req = 4'b0000;
        end
        checks++;
        if ({busy, grant} !== 5'b0) begin
            failures++;
            $display("FAIL low_idle busy=%b grant=%b exp 0", busy, grant);
        end
        tick();
        for (int c = 0; c < 220; c++) begin
            exp = {(c == 0) ? 4'b0010 : 4'b0000, (c < 200) ? exp_tone(3, c) : 1'b0,
                   1'b1, (c == 200), 2'd1};
            got = {grant, piezo_out, busy, done, active_id};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL low_id1 c=%0d got=%b exp=%b", c, got, exp);
            end
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({busy, grant} !== 5'b0) begin
                failures++;
                $display("FAIL low_coalesce c=%0d busy=%b grant=%b exp 0", c, busy, grant);
            end
            tick();
        end
    endtask

    task automatic test_end_coincide;
        logic [9:0] got, exp;
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        for (int c = 0; c < 220; c++) begin
            exp = {(c == 0) ? 4'b0100 : 4'b0000, (c < 200) ? exp_tone(2, c) : 1'b0,
                   1'b1, (c == 200), 2'd2};
            got = {grant, piezo_out, busy, done, active_id};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL end_coincide c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 199) req = 4'b0001;
            if (c == 205) req = 4'b1000;
            tick();
            req = 4'b0000;
        end
        checks++;
        if ({busy, grant} !== 5'b0) begin
            failures++;
            $display("FAIL end_idle busy=%b grant=%b exp 0", busy, grant);
        end
        tick();
        for (int c = 0; c < 220; c++) begin
            exp = {(c == 0) ? 4'b1000 : 4'b0000, (c < 200) ? exp_tone(1, c) : 1'b0,
                   1'b1, (c == 200), 2'd3};
            got = {grant, piezo_out, busy, done, active_id};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL gap_req_id3 c=%0d got=%b exp=%b", c, got, exp);
            end
            tick();
        end
        tick();
        got = {grant, piezo_out, busy, done, active_id};
        exp = {4'b0001, 1'b1, 1'b1, 1'b0, 2'd0};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL end_pending_id0 got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_preempt_at_end;
        logic [9:0] got, exp;
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        repeat (199) tick();
        req = 4'b1000;
        tick();
        req = 4'b0000;
        got = {grant, piezo_out, busy, done, active_id};
        exp = {4'b1000, 1'b1, 1'b1, 1'b0, 2'd3};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL preempt_at_end got=%b exp=%b", got, exp);
        end
        tick();
        got = {grant, piezo_out, busy, done, active_id};
        exp = {4'b0000, 1'b0, 1'b1, 1'b0, 2'd3};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL preempt_at_end_next got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] got;
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        for (int c = 0; c < 102; c++) begin
            if (c == 20) req = 4'b0001;
            tick();
            req = 4'b0000;
        end
        checks++;
        if ({piezo_out, busy} !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid_pre piezo=%b busy=%b exp 1 1", piezo_out, busy);
        end
        rst = 1'b1;
        #1;
        got = {grant, piezo_out, busy, done, active_id};
        checks++;
        if (got !== 10'b0) begin
            failures++;
            $display("FAIL reset_mid_async got=%b exp=%b", got, 10'b0);
        end
        #1 rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            checks++;
            if ({busy, grant, piezo_out} !== 6'b0) begin
                failures++;
                $display("FAIL reset_mid_silent c=%0d busy=%b grant=%b piezo=%b exp 0",
                         c, busy, grant, piezo_out);
            end
        end
    endtask

`ifdef PIEZO_MUTE_EN
    task automatic test_mute;
        logic [9:0] got, exp;
        do_reset();
        mute = 1'b1;
        req = 4'b1000;
        tick();
        req = 4'b0000;
        for (int c = 0; c < 221; c++) begin
            exp = {(c == 0) ? 4'b1000 : 4'b0000, 1'b0, (c < 220), (c == 200), 2'd3};
            got = {grant, piezo_out, busy, done, active_id};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL mute c=%0d got=%b exp=%b", c, got, exp);
            end
            tick();
        end
        mute = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_tone();
        test_simultaneous();
        test_preempt();
        test_low_during_play();
        test_end_coincide();
        test_preempt_at_end();
        test_reset_mid();
`ifdef PIEZO_MUTE_EN
        test_mute();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
